fifo_flags: RTL

- Parametrised synchronous single-clock FIFO; next generation of the lab FIFO.
- Adds arbitrary (non-power-of-2) depth, a selectable read mode (registered or first-word-fall-through), occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with clear.
- Sits between a producer and a consumer on the same clock domain; drop-in for the lab FIFO where status reporting is needed.

---
 rtl/fifo_flags.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo_flags.sv
// Single-clock FIFO with arbitrary depth, selectable registered or fall-through read,
// occupancy count, programmable almost thresholds and sticky overflow/underflow flags.
module fifo_flags #(
   parameter int DATA_SIZE        = 8,
   parameter int FIFO_CAPACITY    = 10,
   parameter int FWFT             = 0,
   parameter int ALMOST_FULL_LVL  = FIFO_CAPACITY - 2,
   parameter int ALMOST_EMPTY_LVL = 2,
   parameter int CNT_W            = $clog2(FIFO_CAPACITY + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_SIZE-1:0] writeData,
   output logic [DATA_SIZE-1:0] readData,
   input  logic                 clearErr,
   output logic [CNT_W-1:0]     count,
   output logic                 empty,
   output logic                 full,
   output logic                 almostFull,
   output logic                 almostEmpty,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int PTR_W = $clog2(FIFO_CAPACITY);

   logic [DATA_SIZE-1:0] mem [FIFO_CAPACITY];
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [CNT_W-1:0]     count_reg;
   logic [CNT_W-1:0]     count_next;
   logic                 ovf_reg;
   logic                 udf_reg;
   logic                 is_empty;
   logic                 is_full;
   logic                 bypass;
   logic                 wr_en;
   logic                 rd_en;
   logic                 ovf_set;
   logic                 udf_set;

   // Pointers wrap at the capacity, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_CAPACITY - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == CNT_W'(FIFO_CAPACITY));

   // In registered-read mode a simultaneous push+pop on an empty FIFO passes the word straight through.
   assign bypass  = (FWFT == 0) && push && pop && is_empty;
   assign wr_en   = push && !bypass && (!is_full || pop);
   assign rd_en   = pop && !is_empty;
   assign ovf_set = push && !pop && is_full;
   assign udf_set = pop && is_empty && !bypass;

   always_comb begin
      count_next = count_reg;
      if (wr_en && !rd_en)
         count_next = count_reg + CNT_W'(1);
      else if (rd_en && !wr_en)
         count_next = count_reg - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
         udf_reg    <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (rd_en)
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         count_reg <= count_next;
         // A new error in the same cycle as clearErr keeps the flag set.
         ovf_reg   <= ovf_set | (ovf_reg & ~clearErr);
         udf_reg   <= udf_set | (udf_reg & ~clearErr);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= writeData;
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [DATA_SIZE-1:0] rdata_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               rdata_reg <= '0;
            else if (bypass)
               rdata_reg <= writeData;
            else if (rd_en)
               rdata_reg <= mem[rd_ptr_reg];
         end
         assign readData = rdata_reg;
      end else begin : g_fwft_read
         assign readData = is_empty ? '0 : mem[rd_ptr_reg];
      end
   endgenerate

   assign count       = count_reg;
   assign empty       = is_empty;
   assign full        = is_full;
   assign almostFull  = (count_reg >= CNT_W'(ALMOST_FULL_LVL));
   assign almostEmpty = (count_reg <= CNT_W'(ALMOST_EMPTY_LVL));
   assign overflow    = ovf_reg;
   assign underflow   = udf_reg;

endmodule
